// File: rtl/ram_64x8_pkg.sv
// Shared constants and types for the 64x8 scratch RAM.
// Default geometry is 64 words of 8 bits; wider or deeper instances
// override the parameters on ram_64x8 directly.
package ram_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 6;

  typedef logic [RAM_DATA_W-1:0] ram_word_t;
  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;

endpackage : ram_pkg

// File: rtl/ram_64x8_if.sv
// Command/data bus of the scratch RAM: write enable, shared address,
// write data and registered read data. The master drives commands, the
// RAM (slave) returns data_out. There is no handshake; every cycle is a
// new command.
interface ram_if
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    output we,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  we,
    input  addr,
    input  data_in,
    output data_out
  );

endinterface : ram_if

// File: rtl/ram_64x8_array.sv
// Storage array and write port of the scratch RAM.
// Optional macro RAM_RESET_CLEAR_EN: when defined, a reset edge clears
// every word to 0. When undefined, reset leaves the contents untouched so
// the array maps onto block RAM; power-up contents are undefined.
// The read side is a plain combinational lookup; the owning module
// registers it, which keeps the read-first behaviour and lets synthesis
// fold the output register into the RAM primitive.
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef RAM_RESET_CLEAR_EN
  // Write port; a reset edge wipes the whole array and suppresses the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end
`else
  // Write port; reset only blocks the write, contents persist.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[wr_addr] <= wr_data;
    end
  end
`endif

  assign rd_data = mem[rd_addr];

endmodule : ram_array

// File: rtl/ram_64x8.sv
// Single-port synchronous scratch RAM, 64x8 by default.
// One shared address, write enable, registered read port with read-first
// behaviour on a same-address read-during-write. data_out updates on
// every non-reset edge regardless of we.
// Optional macro RAM_RESET_CLEAR_EN (handled in ram_array) clears the
// storage on reset.
module ram_64x8
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic     clk,
  input  logic     rst,
  ram_if.slave     bus
);

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;

  // Single port: reads and writes share the command address.
  assign rd_addr = bus.addr;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.we),
    .wr_addr (bus.addr),
    .wr_data (bus.data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  // Output register samples the pre-write word, giving read-first data.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out <= '0;
    end else begin
      bus.data_out <= rd_word;
    end
  end

endmodule : ram_64x8

// File: tb/tb_ram_64x8.sv
// Self-checking bench for ram_64x8 using a scoreboard queue.
// Stimulus is driven on the falling edge; when a command's read result is
// checkable its expected value goes into the queue and the monitor pops and
// compares it 1 time unit after the rising edge that produced data_out.
// Expectations depend on RAM_RESET_CLEAR_EN where the bench is built with it.
module tb_ram_64x8;

  logic clk;
  logic rst;

  ram_if bus ();

  ram_64x8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] exp_q [$];
  string      name_q [$];
  bit         chk_now;
  int         n_checks;
  int         n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command for the next rising edge; optionally queue its expected read data.
  task automatic applyStimulus(input logic r, input logic w, input logic [5:0] a,
                               input logic [7:0] d, input bit chk,
                               input logic [7:0] exp, input string name);
    @(negedge clk);
    rst         = r;
    bus.we      = w;
    bus.addr    = a;
    bus.data_in = d;
    chk_now     = chk;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
  endtask

  // Compare one observed value against the scoreboard head.
  task automatic checkOutput(input logic [7:0] act);
    logic [7:0] exp;
    string      name;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_underflow: got %02h, no expected value queued", act);
    end else begin
      exp  = exp_q.pop_front();
      name = name_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("[TB] FAIL %s: data_out=%02h expected=%02h", name, act, exp);
      end
    end
  endtask

  // Monitor: after each rising edge, compare data_out if that edge's command was checkable.
  initial begin
    bit take;
    forever begin
      @(posedge clk);
      take = chk_now;
      #1;
      if (take) checkOutput(bus.data_out);
    end
  end

  initial begin
    logic [7:0] exp_a0;
    logic [7:0] exp_a7;
`ifdef RAM_RESET_CLEAR_EN
    exp_a0 = 8'h00;
    exp_a7 = 8'h00;
`else
    exp_a0 = 8'h01;
    exp_a7 = 8'h77;
`endif
    n_checks    = 0;
    n_fail      = 0;
    chk_now     = 1'b0;
    rst         = 1'b1;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;

    // 1: reset for two cycles, then write 1,2,3 to addresses 0..2
    applyStimulus(1, 0, 6'd0, 8'h00, 1, 8'h00, "reset_0");
    applyStimulus(1, 1, 6'd3, 8'h99, 1, 8'h00, "reset_1");
    applyStimulus(0, 1, 6'd0, 8'h01, 0, 8'h00, "wr0");
    applyStimulus(0, 1, 6'd1, 8'h02, 0, 8'h00, "wr1");
    applyStimulus(0, 1, 6'd2, 8'h03, 0, 8'h00, "wr2");
    // 2: read back
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 8'h01, "rd0");
    applyStimulus(0, 0, 6'd1, 8'h00, 1, 8'h02, "rd1");
    applyStimulus(0, 0, 6'd2, 8'h00, 1, 8'h03, "rd2");
    // 3: overwrite address 1 (read-first shows old 0x02)
    applyStimulus(0, 1, 6'd1, 8'h04, 1, 8'h02, "ovw1_old");
    applyStimulus(0, 0, 6'd1, 8'h00, 1, 8'h04, "rd1_new");
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 8'h01, "rd0_keep");
    applyStimulus(0, 0, 6'd2, 8'h00, 1, 8'h03, "rd2_keep");
    // 4: read-during-write at address 5, plus a deterministic one at address 2
`ifdef RAM_RESET_CLEAR_EN
    applyStimulus(0, 1, 6'd5, 8'h55, 1, 8'h00, "rdw5_old");
`else
    applyStimulus(0, 1, 6'd5, 8'h55, 0, 8'h00, "rdw5_old");
`endif
    applyStimulus(0, 0, 6'd5, 8'h00, 1, 8'h55, "rd5_new");
    applyStimulus(0, 1, 6'd2, 8'h66, 1, 8'h03, "rdw2_old");
    applyStimulus(0, 0, 6'd2, 8'h00, 1, 8'h66, "rd2_new");
    // 5: reset with a write pending must not write address 7
    applyStimulus(0, 1, 6'd7, 8'h77, 0, 8'h00, "wr7");
    applyStimulus(0, 0, 6'd7, 8'h00, 1, 8'h77, "rd7_pre");
    applyStimulus(1, 1, 6'd7, 8'hAA, 1, 8'h00, "rst_we_out");
    applyStimulus(0, 0, 6'd7, 8'h00, 1, exp_a7, "rd7_post_rst");
    applyStimulus(0, 0, 6'd0, 8'h00, 1, exp_a0, "rd0_post_rst");
    // 6: top address
    applyStimulus(0, 1, 6'd63, 8'hFF, 0, 8'h00, "wr63");
    applyStimulus(0, 0, 6'd63, 8'h00, 1, 8'hFF, "rd63");
    applyStimulus(0, 0, 6'd0, 8'h00, 1, exp_a0, "rd0_after63");
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 8'h00, "idle");

    // Drain: bounded wait for the monitor to consume every queued expectation.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_64x8
